// File: rtl/physics_unit_param.sv
// physics_unit_param: per-fighter fixed-point physics engine.
// Integrates velocity/position once per divided tick and runs the
// GROUND/AIR/HITSTUN movement machine (multi-jump, scaled knockback,
// terminal velocity, saturating position).
// Optional feature macro: PHYS_FASTFALL_EN (joystick-down fast-fall in AIR).
module physics_unit_param #(
   parameter int                      INT_W         = 16,
   parameter int                      FRAC_W        = 16,
   parameter int                      TICK_DIV      = 1024,
   parameter int                      MAX_JUMPS     = 2,
   parameter logic [INT_W+FRAC_W-1:0] JUMP_VEL      = 32'h0004_0000,
   parameter logic [INT_W+FRAC_W-1:0] TERM_VEL      = 32'h0008_0000,
   parameter logic [INT_W+FRAC_W-1:0] ACCEL         = 32'h0000_1000,
   parameter int                      HITSTUN_TICKS = 30
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [2*INT_W-1:0]   start_position,
   input  logic [FRAC_W-1:0]    gravity,
   input  logic [3:0]           mass_shift,
   input  logic [7:0]           joy_x,
   input  logic [7:0]           joy_y,
   input  logic                 jump_btn,
   input  logic [4:0]           wall,
   input  logic                 attack_in,
   input  logic [2*INT_W-1:0]   knockback,
   input  logic [15:0]          damage,
   input  logic                 freeze_in,
   output logic [2*INT_W-1:0]   position,
   output logic [1:0]           state,
   output logic [2:0]           jumps_used,
   output logic                 tick
);

   localparam int W  = INT_W + FRAC_W;
   localparam int CW = $clog2(TICK_DIV);
   localparam int HW = $clog2(HITSTUN_TICKS + 1);
   localparam int PW = INT_W + 18;

   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HS_INIT  = HW'(HITSTUN_TICKS);
   localparam logic [2:0]    MAXJ     = 3'(MAX_JUMPS);

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_AIR    = 2'd1,
      ST_HIT    = 2'd2
   } st_e;

   // registered state
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                btn_prev_q, btn_prev_d;
   logic                up_prev_q, up_prev_d;
   logic                atk_prev_q, atk_prev_d;
   logic                jump_pend_q, jump_pend_d;
   logic                hit_pend_q, hit_pend_d;
   logic signed [W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic signed [W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
   st_e                 st_q, st_d;
   logic [2:0]          jumps_q, jumps_d;
   logic [HW-1:0]       hs_q, hs_d;

   // combinational helpers
   logic                tick_en, joy_up, jump_edge, hit_edge, jump_now, hit_now, floor;
   logic signed [8:0]   sjoy;
   logic signed [W-1:0] sjoy_ext, target_vx, vx_step, vy_grav, kbv_x, kbv_y;
   logic signed [W:0]   dx, acc_w, g_eff, lim, lim_neg, vyg_wide;
   logic signed [PW-1:0] kb_x_ext, kb_y_ext, scale, prod_x, prod_y, prod_x_sh, prod_y_sh;
   logic signed [W-1:0] nvx, nvy;
   st_e                 nst;
   logic [2:0]          njmp;
   logic [HW-1:0]       nhs;
   logic                unused_bits;

   // Signed add that clamps to the W-bit limits instead of wrapping.
   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {a[W-1], a} + {b[W-1], b};
      if (s[W] != s[W-1])
         sat_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         sat_add = s[W-1:0];
   endfunction

   assign tick_en    = (cnt_q == CNT_LAST) && !freeze_in;
   assign joy_up     = (joy_y >= 8'd240);
   assign jump_edge  = (jump_btn && !btn_prev_q) || (joy_up && !up_prev_q);
   assign hit_edge   = attack_in && !atk_prev_q;
   // an edge landing in the tick cycle itself is consumed by that tick
   assign jump_now   = jump_pend_q || (jump_edge && !freeze_in);
   assign hit_now    = hit_pend_q  || (hit_edge  && !freeze_in);
   assign floor      = wall[1] || (wall[4] && (joy_y >= 8'd16));

   // Joystick target velocity and knockback velocity (integer kb scaled by (128+damage)/128).
   always_comb begin
      sjoy      = $signed({1'b0, joy_x}) - 9'sd128;
      sjoy_ext  = {{(W-9){sjoy[8]}}, sjoy};
      target_vx = (sjoy_ext <<< (FRAC_W - 8)) >>> mass_shift;
      kb_x_ext  = {{18{knockback[2*INT_W-1]}}, knockback[2*INT_W-1:INT_W]};
      kb_y_ext  = {{18{knockback[INT_W-1]}}, knockback[INT_W-1:0]};
      scale     = {{(PW-16){1'b0}}, damage} + PW'(128);
      prod_x    = kb_x_ext * scale;
      prod_y    = kb_y_ext * scale;
      prod_x_sh = prod_x >>> 7;
      prod_y_sh = prod_y >>> 7;
      kbv_x     = {prod_x_sh[INT_W-1:0], {FRAC_W{1'b0}}};
      kbv_y     = {prod_y_sh[INT_W-1:0], {FRAC_W{1'b0}}};
   end

   assign unused_bits = ^{prod_x_sh[PW-1:INT_W], prod_y_sh[PW-1:INT_W]};

   // Air x-velocity ramp and gravity with terminal-speed clamp.
   always_comb begin
      acc_w = $signed({1'b0, ACCEL});
      dx    = $signed({target_vx[W-1], target_vx}) - $signed({vel_x_q[W-1], vel_x_q});
      if (dx > acc_w)
         vx_step = vel_x_q + ACCEL;
      else if (dx < -acc_w)
         vx_step = vel_x_q - ACCEL;
      else
         vx_step = target_vx;
`ifdef PHYS_FASTFALL_EN
      if (st_q == ST_AIR && (vel_y_q[W-1] || ~|vel_y_q) && joy_y < 8'd16) begin
         g_eff = $signed({{(INT_W-1){1'b0}}, gravity, 1'b0});
         lim   = $signed({TERM_VEL, 1'b0});
      end else begin
         g_eff = $signed({{INT_W{1'b0}}, 1'b0, gravity});
         lim   = $signed({1'b0, TERM_VEL});
      end
`else
      g_eff = $signed({{INT_W{1'b0}}, 1'b0, gravity});
      lim   = $signed({1'b0, TERM_VEL});
`endif
      lim_neg  = -lim;
      vyg_wide = $signed({vel_y_q[W-1], vel_y_q}) - g_eff;
      vy_grav  = (vyg_wide < lim_neg) ? lim_neg[W-1:0] : vyg_wide[W-1:0];
   end

   // Tick divider, edge history and sticky pending flags.
   always_comb begin
      cnt_d       = freeze_in ? cnt_q : ((cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1);
      btn_prev_d  = jump_btn;
      up_prev_d   = joy_up;
      atk_prev_d  = attack_in;
      jump_pend_d = jump_now;
      hit_pend_d  = hit_now;
      if (tick_en) begin
         jump_pend_d = 1'b0;
         hit_pend_d  = 1'b0;
      end
   end

   // Per-tick movement update: hit > landing > jump > normal, then walls, then integrate.
   always_comb begin
      nvx  = vel_x_q;
      nvy  = vel_y_q;
      nst  = st_q;
      njmp = jumps_q;
      nhs  = hs_q;
      unique case (st_q)
         ST_GROUND: begin
            nvx = target_vx;
            nvy = '0;
            if (!floor) begin
               nst  = ST_AIR;
               njmp = 3'd1;
            end
         end
         ST_AIR: begin
            nvx = vx_step;
            if (floor && (vel_y_q[W-1] || ~|vel_y_q)) begin
               nst  = ST_GROUND;
               nvy  = '0;
               njmp = 3'd0;
            end else begin
               nvy = vy_grav;
            end
         end
         default: begin
            nvy = vy_grav;
            nhs = (hs_q == '0) ? '0 : hs_q - 1'b1;
            if (hs_q <= HW'(1)) begin
               if (floor) begin
                  nst  = ST_GROUND;
                  nvy  = '0;
                  njmp = 3'd0;
               end else begin
                  nst  = ST_AIR;
               end
            end
         end
      endcase
      // jump follows any landing on the same tick, so a land+jump leaves one jump used
      if (jump_now && st_q != ST_HIT && njmp < MAXJ) begin
         nvy  = JUMP_VEL;
         njmp = njmp + 3'd1;
         nst  = ST_AIR;
      end
      if (hit_now) begin
         nvx  = kbv_x;
         nvy  = kbv_y;
         nst  = ST_HIT;
         nhs  = HS_INIT;
         njmp = jumps_q;
      end
      if (wall[3] && nvx[W-1])                nvx = '0;
      if (wall[2] && !nvx[W-1] && |nvx)       nvx = '0;
      if (wall[0] && !nvy[W-1] && |nvy)       nvy = '0;

      vel_x_d = vel_x_q;
      vel_y_d = vel_y_q;
      st_d    = st_q;
      jumps_d = jumps_q;
      hs_d    = hs_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      if (tick_en) begin
         vel_x_d = nvx;
         vel_y_d = nvy;
         st_d    = nst;
         jumps_d = njmp;
         hs_d    = nhs;
         pos_x_d = sat_add(pos_x_q, nvx);
         pos_y_d = sat_add(pos_y_q, nvy);
      end
   end

   // State register: everything clears to the spawn condition on reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q       <= '0;
         btn_prev_q  <= 1'b0;
         up_prev_q   <= 1'b0;
         atk_prev_q  <= 1'b0;
         jump_pend_q <= 1'b0;
         hit_pend_q  <= 1'b0;
         pos_x_q     <= {start_position[2*INT_W-1:INT_W], {FRAC_W{1'b0}}};
         pos_y_q     <= {start_position[INT_W-1:0], {FRAC_W{1'b0}}};
         vel_x_q     <= '0;
         vel_y_q     <= '0;
         st_q        <= ST_AIR;
         jumps_q     <= 3'd1;
         hs_q        <= '0;
      end else begin
         cnt_q       <= cnt_d;
         btn_prev_q  <= btn_prev_d;
         up_prev_q   <= up_prev_d;
         atk_prev_q  <= atk_prev_d;
         jump_pend_q <= jump_pend_d;
         hit_pend_q  <= hit_pend_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         vel_x_q     <= vel_x_d;
         vel_y_q     <= vel_y_d;
         st_q        <= st_d;
         jumps_q     <= jumps_d;
         hs_q        <= hs_d;
      end
   end

   assign position   = {pos_x_q[W-1:FRAC_W], pos_y_q[W-1:FRAC_W]};
   assign state      = st_q;
   assign jumps_used = jumps_q;
   assign tick       = tick_en;

endmodule
